i2c_arbiter: RTL and testbench
==============================

I2C_ARBITER -- requirements
Module: i2c_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 250_000 (5 ms at 50 MHz), meaning the WAIT-state watchdog limit in dri_clk cycles.
REQ-002 SHALL have ports dri_clk, in, 1, the single clock; rst, in, 1, reset, synchronous and active-high.
REQ-003 SHALL have, for each requester k in {0,1}:
- mk_req, in, 1, level request held until serviced;
- mk_rh_wl, in, 1, 1=read, 0=write;
- mk_bit_ctrl, in, 1, 1=16-bit, 0=8-bit word address;
- mk_addr, in, 16, word address;
- mk_data_w, in, 8, write byte;
- mk_gnt, out, 1, transaction owned by requester k;
- mk_done, out, 1, one-cycle completion pulse;
- mk_ack, out, 1, 1=slave NACK or timeout error;
- mk_data_r, out, 8, read byte, valid with mk_done.
REQ-004 SHALL have the I2C driver side:
- i2c_exec, out, 1, one-cycle start pulse;
- i2c_rh_wl, out, 1;
- bit_ctrl, out, 1;
- i2c_addr, out, 16;
- i2c_data_w, out, 8;
- i2c_done, in, 1, driver completion pulse;
- i2c_ack, in, 1, driver error flag;
- i2c_data_r, in, 8;
- busy, out, 1, state not IDLE;
- timeout, out, 1, one-cycle watchdog pulse.

Function
REQ-005 SHALL implement FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE; all outputs registered.
REQ-006 IDLE: requests sampled only here; any mk_req=1 -> ISSUE next cycle; none -> stay.
REQ-007 Arbitration SHALL be round-robin: one requester only -> grant it; both -> grant the one not granted last.
REQ-008 On the IDLE->ISSUE edge SHALL latch the winner's rh_wl/bit_ctrl/addr/data_w onto driver outputs and assert mk_gnt; both held constant until the RESP->IDLE edge.
REQ-009 ISSUE SHALL last exactly one cycle with i2c_exec=1; i2c_exec=0 in every other state.
REQ-010 WAIT SHALL hold until i2c_done=1, then -> RESP; i2c_done in IDLE, ISSUE or RESP SHALL be ignored.
REQ-011 On the WAIT->RESP edge SHALL capture i2c_data_r into mk_data_r and i2c_ack into mk_ack of the granted requester only.
REQ-012 RESP SHALL last one cycle with mk_done=1 for the granted requester; mk_gnt clears on exit.
REQ-013 Requester SHALL deassert mk_req on the edge at which it samples mk_done=1; a req still high in the following IDLE is a new transaction.
REQ-014 Non-granted mk_data_r/mk_ack SHALL hold previous values; mk_done/mk_gnt of the non-granted requester SHALL stay 0.
REQ-015 Request changes during ISSUE/WAIT/RESP SHALL not affect the current transaction.
REQ-016 Minimum turnaround SHALL be 4 cycles (IDLE, ISSUE, WAIT with i2c_done, RESP).

Reset
REQ-017 rst=1 SHALL force IDLE at the next edge, mid-transaction included, with no mk_done issued.
REQ-018 Reset SHALL clear all outputs, mk_data_r and the watchdog counter to 0, and set last-grant to requester 1 so requester 0 wins the first tie.

Configuration
REQ-019 Macro I2C_ARB_TIMEOUT_EN defined: an 18-bit counter clears on WAIT entry and counts in WAIT. Reaching TIMEOUT_CYCLES-1 without i2c_done -> RESP with mk_ack=1, mk_data_r=0, timeout=1 for one cycle.
REQ-020 Macro undefined: no counter, WAIT is unbounded, timeout tied to 0.

Structure
REQ-021 Package i2c_arb_pkg SHALL hold the FSM state typedef (IDLE, ISSUE, WAIT, RESP), the default TIMEOUT_CYCLES, and the address/data width constants (16, 8).
REQ-022 Sub-module rr_arb2 SHALL hold the 2-way round-robin grant logic and last-grant register; the FSM updates last-grant only on IDLE->ISSUE.

Verification
REQ-023 Single m0 write, addr=0x0010, data=0x5A, driver done after 20 cycles -> one i2c_exec pulse carrying those values with i2c_rh_wl=0, m0_done 1 cycle after i2c_done, m1 signals quiet.
REQ-024 m0 and m1 both request from reset -> m0 served first, then m1; repeated simultaneous requests alternate m0, m1, m0.
REQ-025 m1 read, addr=0x00FF, driver returns i2c_data_r=0xC3 with i2c_ack=0 -> m1_data_r=0xC3 and m1_ack=0 on m1_done; m0_data_r unchanged.
REQ-026 Driver pulses i2c_done during ISSUE, then again in WAIT -> first pulse ignored, completion on the second.
REQ-027 rst asserted in WAIT -> IDLE next edge, outputs 0, no mk_done, and the next request is granted normally.
REQ-028 With I2C_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16, no i2c_done -> timeout=1 and m0_done=1 with m0_ack=1 after 16 WAIT cycles; without the macro the arbiter stays in WAIT.

Source files
------------

// File: rtl/i2c_arb_pkg.sv
// Shared types and constants for the two-requester I2C arbiter.
package i2c_arb_pkg;

    localparam int ADDR_W             = 16;
    localparam int DATA_W             = 8;
    localparam int NUM_REQ            = 2;
    localparam int CNT_W              = 18;
    localparam int TIMEOUT_CYCLES_DEF = 250_000;  // 5 ms at 50 MHz

    // FSM state encoding
    typedef logic [1:0] arb_state_t;
    localparam arb_state_t IDLE  = 2'd0;
    localparam arb_state_t ISSUE = 2'd1;
    localparam arb_state_t WAIT  = 2'd2;
    localparam arb_state_t RESP  = 2'd3;

    // One requester's transaction descriptor, in driver-output order
    typedef struct packed {
        logic              rh_wl;
        logic              bit_ctrl;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data_w;
    } arb_req_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant with last-grant memory.
// last=1 means requester 1 won most recently, so requester 0 wins a tie.
module rr_arb2
    import i2c_arb_pkg::*;
(
    input  logic               dri_clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               update,
    output logic [NUM_REQ-1:0] gnt
);

    logic last;

    // Lone requester wins outright; on a tie the one not served last wins
    always_comb begin
        gnt    = '0;
        gnt[0] = req[0] & (~req[1] | last);
        gnt[1] = req[1] & (~req[0] | ~last);
    end

    // Remember the winner only when a transaction is actually launched
    always_ff @(posedge dri_clk) begin
        if (rst)
            last <= 1'b1;
        else if (update)
            last <= gnt[1];
    end

endmodule

// File: rtl/i2c_arbiter.sv
// Arbitrates two requesters onto one I2C byte driver.
// FSM: IDLE -> ISSUE -> WAIT -> RESP -> IDLE, every output registered.
// Optional WAIT watchdog enabled by defining I2C_ARB_TIMEOUT_EN.
module i2c_arbiter
    import i2c_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic              dri_clk,
    input  logic              rst,
    // requester 0
    input  logic              m0_req,
    input  logic              m0_rh_wl,
    input  logic              m0_bit_ctrl,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_data_w,
    output logic              m0_gnt,
    output logic              m0_done,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_data_r,
    // requester 1
    input  logic              m1_req,
    input  logic              m1_rh_wl,
    input  logic              m1_bit_ctrl,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_data_w,
    output logic              m1_gnt,
    output logic              m1_done,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_data_r,
    // I2C driver side
    output logic              i2c_exec,
    output logic              i2c_rh_wl,
    output logic              bit_ctrl,
    output logic [ADDR_W-1:0] i2c_addr,
    output logic [DATA_W-1:0] i2c_data_w,
    input  logic              i2c_done,
    input  logic              i2c_ack,
    input  logic [DATA_W-1:0] i2c_data_r,
    output logic              busy,
    output logic              timeout
);

    arb_state_t                         state, state_n;
    arb_req_t   [NUM_REQ-1:0]           req_in;
    arb_req_t                           sel;
    logic       [NUM_REQ-1:0]           req_v, gnt_w, gnt_r, done_r, ack_r;
    logic       [NUM_REQ-1:0][DATA_W-1:0] data_r_r;
    logic                               take, finish, tmo_hit;

    assign req_v     = {m1_req, m0_req};
    assign req_in[0] = {m0_rh_wl, m0_bit_ctrl, m0_addr, m0_data_w};
    assign req_in[1] = {m1_rh_wl, m1_bit_ctrl, m1_addr, m1_data_w};

    // take: IDLE->ISSUE edge; finish: WAIT->RESP edge
    assign take   = (state == IDLE) && (|req_v);
    assign finish = (state == WAIT) && (i2c_done || tmo_hit);

    rr_arb2 u_rr (
        .dri_clk (dri_clk),
        .rst     (rst),
        .req     (req_v),
        .update  (take),
        .gnt     (gnt_w)
    );

    assign sel = gnt_w[1] ? req_in[1] : req_in[0];

`ifdef I2C_ARB_TIMEOUT_EN
    logic [CNT_W-1:0] wd_cnt;

    // Watchdog: zeroed on the way into WAIT, advances each WAIT cycle
    always_ff @(posedge dri_clk) begin
        if (rst)
            wd_cnt <= '0;
        else if (state == ISSUE)
            wd_cnt <= '0;
        else if (state == WAIT)
            wd_cnt <= wd_cnt + CNT_W'(1);
    end

    // A real completion in the same cycle takes precedence over the watchdog
    assign tmo_hit = (state == WAIT) && !i2c_done &&
                     (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    // No watchdog: WAIT is unbounded; the parameter stays in the interface
    // so both builds share one instantiation.
    assign tmo_hit = 1'b0 & (TIMEOUT_CYCLES > 0);
`endif

    // Next-state logic; i2c_done is only looked at in WAIT
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (|req_v) state_n = ISSUE;
            ISSUE:   state_n = WAIT;
            WAIT:    if (finish) state_n = RESP;
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // State, driver-side outputs and grant; command latched on launch and
    // held for the whole transaction regardless of later request changes
    always_ff @(posedge dri_clk) begin
        if (rst) begin
            state      <= IDLE;
            busy       <= 1'b0;
            i2c_exec   <= 1'b0;
            i2c_rh_wl  <= 1'b0;
            bit_ctrl   <= 1'b0;
            i2c_addr   <= '0;
            i2c_data_w <= '0;
            gnt_r      <= '0;
            timeout    <= 1'b0;
        end else begin
            state    <= state_n;
            busy     <= (state_n != IDLE);
            i2c_exec <= take;
            timeout  <= tmo_hit;
            if (take) begin
                {i2c_rh_wl, bit_ctrl, i2c_addr, i2c_data_w} <= sel;
                gnt_r <= gnt_w;
            end else if (state == RESP) begin
                gnt_r <= '0;
            end
        end
    end

    // Per-requester response registers; only the granted one updates
    for (genvar k = 0; k < NUM_REQ; k++) begin : g_rsp
        // Done pulse in RESP, read data / error flag captured on WAIT exit
        always_ff @(posedge dri_clk) begin
            if (rst) begin
                done_r[k]   <= 1'b0;
                ack_r[k]    <= 1'b0;
                data_r_r[k] <= '0;
            end else begin
                done_r[k] <= finish && gnt_r[k];
                if (finish && gnt_r[k]) begin
                    ack_r[k]    <= tmo_hit ? 1'b1 : i2c_ack;
                    data_r_r[k] <= tmo_hit ? '0 : i2c_data_r;
                end
            end
        end
    end

    assign m0_gnt    = gnt_r[0];
    assign m1_gnt    = gnt_r[1];
    assign m0_done   = done_r[0];
    assign m1_done   = done_r[1];
    assign m0_ack    = ack_r[0];
    assign m1_ack    = ack_r[1];
    assign m0_data_r = data_r_r[0];
    assign m1_data_r = data_r_r[1];

endmodule

// File: tb/tb_i2c_arbiter.sv
// Self-checking bench for i2c_arbiter: vector table plus corner sequences.
// Timeout sequence adapts to whether I2C_ARB_TIMEOUT_EN is defined.
module tb_i2c_arbiter;

    localparam int TMO = 16;

    logic        dri_clk = 1'b0;
    logic        rst;
    logic        m0_req, m0_rh_wl, m0_bit_ctrl, m0_gnt, m0_done, m0_ack;
    logic [15:0] m0_addr;
    logic [7:0]  m0_data_w, m0_data_r;
    logic        m1_req, m1_rh_wl, m1_bit_ctrl, m1_gnt, m1_done, m1_ack;
    logic [15:0] m1_addr;
    logic [7:0]  m1_data_w, m1_data_r;
    logic        i2c_exec, i2c_rh_wl, bit_ctrl, i2c_done, i2c_ack, busy, timeout;
    logic [15:0] i2c_addr;
    logic [7:0]  i2c_data_w, i2c_data_r;

    i2c_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
        .dri_clk(dri_clk), .rst(rst),
        .m0_req(m0_req), .m0_rh_wl(m0_rh_wl), .m0_bit_ctrl(m0_bit_ctrl),
        .m0_addr(m0_addr), .m0_data_w(m0_data_w), .m0_gnt(m0_gnt),
        .m0_done(m0_done), .m0_ack(m0_ack), .m0_data_r(m0_data_r),
        .m1_req(m1_req), .m1_rh_wl(m1_rh_wl), .m1_bit_ctrl(m1_bit_ctrl),
        .m1_addr(m1_addr), .m1_data_w(m1_data_w), .m1_gnt(m1_gnt),
        .m1_done(m1_done), .m1_ack(m1_ack), .m1_data_r(m1_data_r),
        .i2c_exec(i2c_exec), .i2c_rh_wl(i2c_rh_wl), .bit_ctrl(bit_ctrl),
        .i2c_addr(i2c_addr), .i2c_data_w(i2c_data_w), .i2c_done(i2c_done),
        .i2c_ack(i2c_ack), .i2c_data_r(i2c_data_r), .busy(busy), .timeout(timeout)
    );

    always #5 dri_clk = ~dri_clk;

    typedef struct {
        int         who;
        logic [7:0] dr;
        logic       ack;
    } exp_t;

    typedef struct {
        logic [1:0]       r, rw, bc;
        logic [1:0][15:0] a;
        logic [1:0][7:0]  d;
        int               first, dly;
        logic [7:0]       rd;
        logic             ak;
    } vec_t;

    exp_t       sbq[$];
    vec_t       vt[8];
    logic [7:0] hold_dr[2];
    logic       hold_ack[2];
    int         tests = 0;
    int         fails = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] dr_of(input int k);
        return (k == 1) ? m1_data_r : m0_data_r;
    endfunction

    function automatic logic ack_of(input int k);
        return (k == 1) ? m1_ack : m0_ack;
    endfunction

    task automatic wait_exec(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge dri_clk);
            if (i2c_exec === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // One full transaction for requester 'who', driver completes after dly WAIT cycles
    task automatic do_txn(input int who, input logic rw, input logic bc,
                          input logic [15:0] a, input logic [7:0] dw,
                          input int dly, input logic [7:0] rd, input logic ak);
        bit   ok;
        exp_t e;
        int   oth;
        wait_exec(ok);
        chk("exec_seen", 32'(ok), 32'(1));
        if (!ok) return;
        chk("gnt", 32'({m1_gnt, m0_gnt}), (who == 1) ? 32'h2 : 32'h1);
        chk("rh_wl", 32'(i2c_rh_wl), 32'(rw));
        chk("bit_ctrl", 32'(bit_ctrl), 32'(bc));
        chk("addr", 32'(i2c_addr), 32'(a));
        chk("data_w", 32'(i2c_data_w), 32'(dw));
        chk("busy", 32'(busy), 32'(1));
        sbq.push_back('{who, rd, ak});
        @(negedge dri_clk);
        chk("exec_pulse", 32'(i2c_exec), 32'(0));
        for (int i = 1; i < dly; i++) begin
            chk("early_done", 32'({m1_done, m0_done}), 32'(0));
            @(negedge dri_clk);
        end
        i2c_done = 1'b1; i2c_data_r = rd; i2c_ack = ak;
        @(negedge dri_clk);
        i2c_done = 1'b0; i2c_data_r = 8'h00; i2c_ack = 1'b0;
        e   = sbq.pop_front();
        oth = 1 - e.who;
        chk("done", 32'({m1_done, m0_done}), (e.who == 1) ? 32'h2 : 32'h1);
        chk("data_r", 32'(dr_of(e.who)), 32'(e.dr));
        chk("ack", 32'(ack_of(e.who)), 32'(e.ack));
        chk("hold_data_r", 32'(dr_of(oth)), 32'(hold_dr[oth]));
        chk("hold_ack", 32'(ack_of(oth)), 32'(hold_ack[oth]));
        chk("timeout_quiet", 32'(timeout), 32'(0));
        hold_dr[e.who]  = e.dr;
        hold_ack[e.who] = e.ack;
        if (e.who == 0) m0_req = 1'b0; else m1_req = 1'b0;
        @(negedge dri_clk);
        chk("back_idle", 32'({busy, m1_gnt, m0_gnt, m1_done, m0_done}), 32'(0));
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok, bad;
        int f, s;

        // {r, rw, bc, a[1:0], d[1:0], first, dly, rd, ak}
        vt[0] = '{2'b11, 2'b00, 2'b11, {16'h1234, 16'h0042}, {8'hB1, 8'hA0}, 0, 3, 8'h21, 1'b0};
        vt[1] = '{2'b11, 2'b11, 2'b01, {16'h0007, 16'h8001}, {8'h00, 8'h00}, 0, 1, 8'h96, 1'b0};
        vt[2] = '{2'b01, 2'b00, 2'b01, {16'h0000, 16'h0010}, {8'h00, 8'h5A}, 0, 20, 8'h00, 1'b0};
        vt[3] = '{2'b11, 2'b10, 2'b10, {16'hBEEF, 16'h0101}, {8'h44, 8'h33}, 1, 2, 8'h5C, 1'b0};
        vt[4] = '{2'b10, 2'b10, 2'b00, {16'h00FF, 16'h0000}, {8'h00, 8'h00}, 1, 5, 8'hC3, 1'b0};
        vt[5] = '{2'b01, 2'b01, 2'b00, {16'h0000, 16'h00A5}, {8'h00, 8'h00}, 0, 4, 8'hEE, 1'b1};
        vt[6] = '{2'b10, 2'b00, 2'b10, {16'hFFFF, 16'h0000}, {8'h7E, 8'h00}, 1, 1, 8'h01, 1'b1};
        vt[7] = '{2'b11, 2'b01, 2'b10, {16'h4000, 16'h0002}, {8'h0F, 8'hF0}, 0, 3, 8'h69, 1'b0};

        rst = 1'b1;
        {m0_req, m0_rh_wl, m0_bit_ctrl, m0_addr, m0_data_w} = '0;
        {m1_req, m1_rh_wl, m1_bit_ctrl, m1_addr, m1_data_w} = '0;
        i2c_done = 1'b0; i2c_ack = 1'b0; i2c_data_r = 8'h00;
        hold_dr[0] = 8'h00; hold_dr[1] = 8'h00; hold_ack[0] = 1'b0; hold_ack[1] = 1'b0;
        repeat (3) @(negedge dri_clk);
        chk("rst_ctrl", 32'({busy, i2c_exec, timeout, m0_gnt, m1_gnt, m0_done, m1_done, m0_ack, m1_ack}), 32'(0));
        chk("rst_data", 32'({m0_data_r, m1_data_r}), 32'(0));
        chk("rst_drv", 32'({i2c_rh_wl, bit_ctrl, i2c_addr, i2c_data_w}), 32'(0));
        rst = 1'b0;
        @(negedge dri_clk);
        chk("idle_no_req", 32'({busy, i2c_exec}), 32'(0));

        // Table-driven transactions
        for (int i = 0; i < 8; i++) begin
            m0_req = vt[i].r[0]; m0_rh_wl = vt[i].rw[0]; m0_bit_ctrl = vt[i].bc[0];
            m0_addr = vt[i].a[0]; m0_data_w = vt[i].d[0];
            m1_req = vt[i].r[1]; m1_rh_wl = vt[i].rw[1]; m1_bit_ctrl = vt[i].bc[1];
            m1_addr = vt[i].a[1]; m1_data_w = vt[i].d[1];
            f = vt[i].first;
            s = 1 - f;
            do_txn(f, vt[i].rw[f], vt[i].bc[f], vt[i].a[f], vt[i].d[f], vt[i].dly, vt[i].rd, vt[i].ak);
            if (vt[i].r == 2'b11)
                do_txn(s, vt[i].rw[s], vt[i].bc[s], vt[i].a[s], vt[i].d[s], vt[i].dly + 2, ~vt[i].rd, vt[i].ak);
        end

        // i2c_done during ISSUE is ignored; completion comes from the WAIT pulse
        m0_req = 1'b1; m0_rh_wl = 1'b1; m0_addr = 16'h0321;
        wait_exec(ok);
        chk("issue_exec_seen", 32'(ok), 32'(1));
        i2c_done = 1'b1; i2c_data_r = 8'h77;
        @(negedge dri_clk);
        i2c_done = 1'b0; i2c_data_r = 8'h00;
        bad = 1'b0;
        repeat (3) begin
            if (m0_done !== 1'b0 || busy !== 1'b1) bad = 1'b1;
            @(negedge dri_clk);
        end
        chk("issue_done_ignored", 32'(bad), 32'(0));
        i2c_done = 1'b1; i2c_data_r = 8'h3C;
        @(negedge dri_clk);
        i2c_done = 1'b0; i2c_data_r = 8'h00;
        chk("second_done", 32'({m1_done, m0_done}), 32'h1);
        chk("second_data", 32'(m0_data_r), 32'h3C);
        hold_dr[0] = 8'h3C; hold_ack[0] = 1'b0;
        m0_req = 1'b0;
        @(negedge dri_clk);

        // Reset while in WAIT: straight to IDLE, no done, then normal service
        m0_req = 1'b1; m0_rh_wl = 1'b0; m0_bit_ctrl = 1'b1; m0_addr = 16'h0A0B; m0_data_w = 8'hD2;
        wait_exec(ok);
        chk("rstw_exec_seen", 32'(ok), 32'(1));
        repeat (3) @(negedge dri_clk);
        rst = 1'b1;
        @(negedge dri_clk);
        chk("rstw_ctrl", 32'({busy, i2c_exec, m0_gnt, m1_gnt, m0_done, m1_done, timeout}), 32'(0));
        chk("rstw_data", 32'({m0_data_r, m1_data_r, m0_ack, m1_ack}), 32'(0));
        hold_dr[0] = 8'h00; hold_dr[1] = 8'h00; hold_ack[0] = 1'b0; hold_ack[1] = 1'b0;
        rst = 1'b0;
        do_txn(0, 1'b0, 1'b1, 16'h0A0B, 8'hD2, 2, 8'h4D, 1'b0);

        // Watchdog behaviour with no driver completion
        m0_req = 1'b1; m0_rh_wl = 1'b1; m0_addr = 16'h0055;
        wait_exec(ok);
        chk("tmo_exec_seen", 32'(ok), 32'(1));
        bad = 1'b0;
`ifdef I2C_ARB_TIMEOUT_EN
        for (int i = 0; i < TMO; i++) begin
            @(negedge dri_clk);
            if (m0_done !== 1'b0 || timeout !== 1'b0 || busy !== 1'b1) bad = 1'b1;
        end
        chk("tmo_wait_quiet", 32'(bad), 32'(0));
        @(negedge dri_clk);
        chk("tmo_pulse", 32'({timeout, m0_done, m0_ack}), 32'h7);
        chk("tmo_data_zero", 32'(m0_data_r), 32'(0));
        m0_req = 1'b0;
        @(negedge dri_clk);
        chk("tmo_one_cycle", 32'({timeout, busy, m0_done}), 32'(0));
`else
        for (int i = 0; i < 3 * TMO; i++) begin
            @(negedge dri_clk);
            if (m0_done !== 1'b0 || timeout !== 1'b0 || busy !== 1'b1) bad = 1'b1;
        end
        chk("no_tmo_stays_wait", 32'(bad), 32'(0));
        i2c_done = 1'b1; i2c_data_r = 8'h12;
        @(negedge dri_clk);
        i2c_done = 1'b0; i2c_data_r = 8'h00;
        chk("no_tmo_late_done", 32'({timeout, m0_done, m0_ack}), 32'h2);
        chk("no_tmo_data", 32'(m0_data_r), 32'h12);
        m0_req = 1'b0;
        @(negedge dri_clk);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
